// File: rtl/period_meter_pkg.sv
// Shared types and constants for the multi-channel period meter.
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } ch_state_t;

    // Largest value a WIDTH-bit period counter can hold; reaching it with no edge is a timeout.
    function automatic logic [31:0] sat_count(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic bit params_ok(input int channels, input int width,
                                     input int avg_log2, input int sync_stages);
        return (channels >= 1)    && (channels <= 16) &&
               (width >= 8)       && (width <= 32)    &&
               (avg_log2 >= 0)    && (avg_log2 <= 4)  &&
               (sync_stages >= 2) && (sync_stages <= 3);
    endfunction

endpackage

// File: rtl/period_channel.sv
// One measurement channel: input synchroniser, rising-edge detect, period counter,
// averaging accumulator and timeout.
//
// state   | meaning
// IDLE    | unarmed; counter and accumulator are zero, waiting for an arming edge
// MEASURE | counting clk cycles since the last detected edge
module period_channel
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int AVG_LOG2    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout
);

    localparam int                ACC_W  = WIDTH + AVG_LOG2;
    localparam logic [31:0]       SAT_I  = sat_count(WIDTH);
    localparam logic [WIDTH-1:0]  SAT    = SAT_I[WIDTH-1:0];
    localparam int                LAST_I = (1 << AVG_LOG2) - 1;
    localparam logic [AVG_LOG2:0] LAST   = LAST_I[AVG_LOG2:0];

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;

    ch_state_t         state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [AVG_LOG2:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  period_q, period_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    logic [ACC_W-1:0]  sum;
    logic [WIDTH-1:0]  avg;

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    // The sum of 2^AVG_LOG2 WIDTH-bit samples always fits in ACC_W bits.
    assign sum      = acc_q + ACC_W'(count_q);
    assign avg      = WIDTH'(sum >> AVG_LOG2);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!enable) begin
            state_d   = IDLE;
            count_d   = '0;
            acc_d     = '0;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (edge_det) begin
                        state_d   = MEASURE;
                        count_d   = WIDTH'(1);
                        timeout_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        count_d = WIDTH'(1);
                        if (cnt_q == LAST) begin
                            period_d = avg;
                            valid_d  = 1'b1;
                            acc_d    = '0;
                            cnt_d    = '0;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (count_q == SAT) begin
                        // Signal lost: drop the partial average and wait for a new arming edge.
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        count_d   = '0;
                        acc_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q    <= sync_q[SYNC_STAGES-1];
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: rtl/period_meter.sv
// Multi-channel period meter: CHANNELS independent period_channel instances with packed outputs.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int AVG_LOG2    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       sig_in,
    output logic [CHANNELS*WIDTH-1:0] period,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       timeout
);

    if (!params_ok(CHANNELS, WIDTH, AVG_LOG2, SYNC_STAGES)) begin : g_bad_params
        $error("period_meter: parameter out of range");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        period_channel #(
            .WIDTH      (WIDTH),
            .AVG_LOG2   (AVG_LOG2),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .sig_in (sig_in[i]),
            .period (period[i*WIDTH +: WIDTH]),
            .valid  (valid[i]),
            .timeout(timeout[i])
        );
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: two instances (no averaging / 4-period averaging),
// directed edge sequences, expected results queued per channel and popped on valid.
module tb_period_meter;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, enable;
    logic [1:0]     sig_a, sig_b;
    logic [2*W-1:0] period_a, period_b;
    logic [1:0]     valid_a, valid_b, timeout_a, timeout_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] qa0[$], qa1[$], qb0[$], qb1[$];
    int           gaps[$];

    period_meter #(.CHANNELS(2), .WIDTH(W), .AVG_LOG2(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_a),
        .period(period_a), .valid(valid_a), .timeout(timeout_a)
    );

    period_meter #(.CHANNELS(2), .WIDTH(W), .AVG_LOG2(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_b),
        .period(period_b), .valid(valid_b), .timeout(timeout_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sig(input bit sel, input int ch, input logic v);
        if (sel) sig_b[ch] = v;
        else     sig_a[ch] = v;
    endtask

    task automatic push(input bit sel, input int ch, input logic [W-1:0] v);
        case ({sel, ch[0]})
            2'b00:   qa0.push_back(v);
            2'b01:   qa1.push_back(v);
            2'b10:   qb0.push_back(v);
            default: qb1.push_back(v);
        endcase
    endtask

    // One-cycle pulse to arm, then one pulse per entry of gaps (cycles between rising edges).
    task automatic run_edges(input bit sel, input int ch);
        set_sig(sel, ch, 1'b1); tick(); set_sig(sel, ch, 1'b0);
        foreach (gaps[i]) begin
            repeat (gaps[i] - 1) tick();
            set_sig(sel, ch, 1'b1); tick(); set_sig(sel, ch, 1'b0);
        end
        repeat (5) tick();
    endtask

    task automatic clear();
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (valid_a[0]) begin
            check("a0 valid_expected", int'(qa0.size() != 0), 1);
            if (qa0.size() != 0) check("a0 period", int'(period_a[W-1:0]), int'(qa0.pop_front()));
        end
        if (valid_a[1]) begin
            check("a1 valid_expected", int'(qa1.size() != 0), 1);
            if (qa1.size() != 0) check("a1 period", int'(period_a[2*W-1:W]), int'(qa1.pop_front()));
        end
        if (valid_b[0]) begin
            check("b0 valid_expected", int'(qb0.size() != 0), 1);
            if (qb0.size() != 0) check("b0 period", int'(period_b[W-1:0]), int'(qb0.pop_front()));
        end
        if (valid_b[1]) begin
            check("b1 valid_expected", int'(qb1.size() != 0), 1);
            if (qb1.size() != 0) check("b1 period", int'(period_b[2*W-1:W]), int'(qb1.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; sig_a = '0; sig_b = '0;
        repeat (3) tick();
        check("reset period_a", int'(period_a), 0);
        check("reset period_b", int'(period_b), 0);
        check("reset valid", int'({valid_b, valid_a}), 0);
        check("reset timeout", int'({timeout_b, timeout_a}), 0);
        rst = 1'b0;
        tick();

        // Square wave of period 10 on a0; first edge only arms.
        for (int t = 0; t < 60; t++) begin
            sig_a[0] = ((t % 10) < 5);
            if (t > 0 && t % 10 == 0) push(0, 0, 10);
            tick();
        end
        sig_a = '0;
        repeat (4) tick();
        check("t1 ch0 period", int'(period_a[W-1:0]), 10);
        check("t1 ch1 period", int'(period_a[2*W-1:W]), 0);
        clear();

        // Averaging over 4: (10+10+12+12)/4 = 11, then floor(43/4) = 10.
        push(1, 0, 11); push(1, 0, 10);
        gaps = '{10, 10, 12, 12, 10, 11, 11, 11};
        run_edges(1, 0);
        check("t2 avg period", int'(period_b[W-1:0]), 10);
        clear();

        // Arm, then silence: timeout once the counter saturates at 255.
        gaps.delete();
        run_edges(0, 0);
        repeat (244) tick();
        check("t3 timeout before sat", int'(timeout_a[0]), 0);
        repeat (20) tick();
        check("t3 timeout after sat", int'(timeout_a[0]), 1);
        push(0, 0, 20);
        gaps = '{20};
        run_edges(0, 0);
        check("t3 timeout cleared", int'(timeout_a[0]), 0);
        check("t3 period", int'(period_a[W-1:0]), 20);
        clear();

        // Edge exactly at counter 255 is a valid sample.
        push(0, 0, 255);
        gaps = '{255};
        run_edges(0, 0);
        check("t4 no timeout", int'(timeout_a[0]), 0);
        check("t4 period", int'(period_a[W-1:0]), 255);
        clear();

        // Simultaneous ch0 period 7, ch1 period 13, reset mid-period.
        for (int t = 0; t < 46; t++) begin
            sig_a = {1'(t % 13 == 0), 1'(t % 7 == 0)};
            if (t > 0 && t % 7 == 0)  push(0, 0, 7);
            if (t > 0 && t % 13 == 0) push(0, 1, 13);
            tick();
        end
        sig_a = '0;
        rst = 1'b1;
        repeat (2) tick();
        check("t5 reset period", int'(period_a), 0);
        check("t5 reset valid", int'(valid_a), 0);
        check("t5 reset timeout", int'(timeout_a), 0);
        rst = 1'b0;
        tick();
        for (int t = 0; t < 31; t++) begin
            sig_a = {1'(t % 13 == 0), 1'(t % 7 == 0)};
            if (t > 0 && t % 7 == 0)  push(0, 0, 7);
            if (t > 0 && t % 13 == 0) push(0, 1, 13);
            tick();
        end
        sig_a = '0;
        repeat (4) tick();
        check("t5 post-reset periods", int'(period_a), int'({8'd13, 8'd7}));
        clear();

        // Enable low mid-measurement: period holds, timeout clears, re-arm needed.
        gaps.delete();
        run_edges(0, 1);
        repeat (265) tick();
        check("t6 ch1 timeout", int'(timeout_a[1]), 1);
        push(0, 0, 15);
        gaps = '{15};
        run_edges(0, 0);
        tick();
        enable = 1'b0;
        repeat (5) tick();
        check("t6 period held", int'(period_a[W-1:0]), 15);
        check("t6 timeout cleared", int'(timeout_a), 0);
        enable = 1'b1;
        repeat (20) tick();
        push(0, 0, 9);
        gaps = '{9};
        run_edges(0, 0);
        check("t6 period after re-arm", int'(period_a[W-1:0]), 9);

        repeat (4) tick();
        check("qa0 drained", qa0.size(), 0);
        check("qa1 drained", qa1.size(), 0);
        check("qb0 drained", qb0.size(), 0);
        check("qb1 drained", qb1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
